// File: rtl/prog_bit_router.sv
// prog_bit_router: programmable bit router with a single registered output stage.
// Each output bit picks any input bit, constant 0 or constant 1, optionally
// inverted, from a runtime-writable map. Words move through one pipeline
// register with valid/ready handshakes. A registered parity bit and a
// wrapping transfer counter are provided for debug.
module prog_bit_router #(
  parameter int IN_W  = 20,
  parameter int OUT_W = 40,
  parameter int SEL_W = $clog2(IN_W + 2),
  parameter int CNT_W = 16,
  localparam int IDX_W = (OUT_W > 1) ? $clog2(OUT_W) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_par,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_idx,
  input  logic [SEL_W-1:0] cfg_sel,
  input  logic             cfg_inv,
  output logic             cfg_err,
  output logic [CNT_W-1:0] xfer_cnt
);

  // Map storage: one {sel, inv} entry per output bit.
  logic [OUT_W-1:0][SEL_W-1:0] sel_q;
  logic [OUT_W-1:0]            inv_q;

  // Source vector indexed directly by the selector code:
  // codes 0..IN_W-1 pick in_data, IN_W is constant 0, IN_W+1 is constant 1.
  logic [IN_W+1:0]  src_vec;
  logic [OUT_W-1:0] routed;
  logic             cfg_legal;
  logic             in_fire;
  logic             out_fire;

  assign in_ready  = !out_valid || out_ready;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;
  assign cfg_legal = (int'(cfg_idx) < OUT_W) && (int'(cfg_sel) <= IN_W + 1);
  assign src_vec   = {1'b1, 1'b0, in_data};

  // Combinational routing of the incoming word through the current map.
  always_comb begin
    routed = '0;
    for (int j = 0; j < OUT_W; j++) begin
      routed[j] = src_vec[sel_q[j]] ^ inv_q[j];
    end
  end

  // Map writes and sticky illegal-write flag; the map reset default is j mod IN_W.
  // The map updates at the same edge that may capture a word, so that word
  // is routed with the old map.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < OUT_W; j++) begin
        sel_q[j] <= SEL_W'(j % IN_W);
        inv_q[j] <= 1'b0;
      end
      cfg_err <= 1'b0;
    end else if (cfg_we) begin
      if (cfg_legal) begin
        sel_q[cfg_idx] <= cfg_sel;
        inv_q[cfg_idx] <= cfg_inv;
      end else begin
        cfg_err <= 1'b1;
      end
    end
  end

  // Output pipeline register: capture on input transfer, drain on output transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_par   <= 1'b0;
    end else if (in_fire) begin
      out_valid <= 1'b1;
      out_data  <= routed;
      out_par   <= ^routed;
    end else if (out_fire) begin
      out_valid <= 1'b0;
    end
  end

  // Completed output transfer counter, wraps silently.
  always_ff @(posedge clk) begin
    if (rst) begin
      xfer_cnt <= '0;
    end else if (out_fire) begin
      xfer_cnt <= xfer_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_prog_bit_router.sv
// Testbench for prog_bit_router: directed scenarios plus randomized traffic,
// checked by a scoreboard fed from a behavioural map model.
module tb_prog_bit_router;

  localparam int IN_W  = 20;
  localparam int OUT_W = 40;
  localparam int CNT_M = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [IN_W-1:0]  in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [OUT_W-1:0] out_data;
  logic             out_par;
  logic             cfg_we = 1'b0;
  logic [5:0]       cfg_idx = '0;
  logic [4:0]       cfg_sel = '0;
  logic             cfg_inv = 1'b0;
  logic             cfg_err;
  logic [3:0]       xfer_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int          m_sel[OUT_W];
  bit          m_inv[OUT_W];
  bit          m_valid;
  bit          m_err;
  int          m_cnt;
  logic [OUT_W:0] sb_q[$];

  prog_bit_router #(.IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_par(out_par),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_sel(cfg_sel), .cfg_inv(cfg_inv),
    .cfg_err(cfg_err), .xfer_cnt(xfer_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Output bit j = source(sel_j) xor inv_j, source = data bit, 0 or 1.
  function automatic logic [OUT_W-1:0] route(input logic [IN_W-1:0] d);
    logic [OUT_W-1:0] r;
    bit b;
    for (int j = 0; j < OUT_W; j++) begin
      if (m_sel[j] < IN_W) b = d[m_sel[j]];
      else                 b = (m_sel[j] == IN_W + 1);
      r[j] = b ^ m_inv[j];
    end
    return r;
  endfunction

  function automatic void model_reset();
    for (int j = 0; j < OUT_W; j++) begin
      m_sel[j] = j % IN_W;
      m_inv[j] = 1'b0;
    end
    m_valid = 1'b0;
    m_err   = 1'b0;
    m_cnt   = 0;
    sb_q.delete();
  endfunction

  // Monitor: whenever a word is presented it must match the scoreboard head;
  // the head is retired when the downstream accepts it.
  always @(negedge clk) begin
    if (rst == 1'b0 && out_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_word", {24'd0, out_data}, 64'd0);
      end else begin
        chk("sb_data", {24'd0, out_data}, {24'd0, sb_q[0][OUT_W-1:0]});
        chk("sb_par", {63'd0, out_par}, {63'd0, sb_q[0][OUT_W]});
        if (out_ready) void'(sb_q.pop_front());
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cfg_we = 1'b0;
    @(posedge clk); #1;
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_out_data", {24'd0, out_data}, 64'd0);
    chk("rst_out_par", {63'd0, out_par}, 64'd0);
    chk("rst_cfg_err", {63'd0, cfg_err}, 64'd0);
    chk("rst_xfer_cnt", {60'd0, xfer_cnt}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  // One clock of stimulus; model is advanced with the map as it stood
  // before this edge's write.
  task automatic cycle(input bit v, input logic [IN_W-1:0] d, input bit rdy,
                       input bit we, input logic [5:0] idx, input logic [4:0] sel,
                       input bit inv);
    bit fire;
    logic [OUT_W-1:0] w;
    in_valid = v; in_data = d; out_ready = rdy;
    cfg_we = we; cfg_idx = idx; cfg_sel = sel; cfg_inv = inv;
    @(negedge clk);
    chk("out_valid", {63'd0, out_valid}, {63'd0, m_valid});
    chk("in_ready", {63'd0, in_ready}, {63'd0, (!m_valid || rdy)});
    chk("cfg_err", {63'd0, cfg_err}, {63'd0, m_err});
    chk("xfer_cnt", {60'd0, xfer_cnt}, 64'(m_cnt));
    fire = v && (!m_valid || rdy);
    if (fire) begin
      w = route(d);
      sb_q.push_back({^w, w});
    end
    if (m_valid && rdy) m_cnt = (m_cnt + 1) % CNT_M;
    if (fire) m_valid = 1'b1;
    else if (rdy) m_valid = 1'b0;
    if (we) begin
      if (int'(idx) < OUT_W && int'(sel) <= IN_W + 1) begin
        m_sel[idx] = int'(sel);
        m_inv[idx] = inv;
      end else begin
        m_err = 1'b1;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [IN_W-1:0] d, input bit rdy);
    cycle(1'b1, d, rdy, 1'b0, 6'd0, 5'd0, 1'b0);
  endtask

  task automatic idle(input bit rdy);
    cycle(1'b0, '0, rdy, 1'b0, 6'd0, 5'd0, 1'b0);
  endtask

  task automatic cfg(input logic [5:0] idx, input logic [4:0] sel, input bit inv);
    cycle(1'b0, '0, 1'b1, 1'b1, idx, sel, inv);
  endtask

  logic [OUT_W-1:0] exp_a;

  initial begin
    model_reset();
    do_reset();

    // Default map
    send(20'h8_0001, 1'b1);
    chk("dflt_data", {24'd0, out_data}, {24'd0, 40'h80001_80001});
    chk("dflt_par", {63'd0, out_par}, 64'd0);
    idle(1'b1);
    chk("dflt_cnt", {60'd0, xfer_cnt}, 64'd1);

    // Constants and inversion
    cfg(6'd7, 5'd20, 1'b0);
    cfg(6'd8, 5'd21, 1'b0);
    cfg(6'd4, 5'd20, 1'b1);
    send(20'h0, 1'b1);
    chk("const_data", {24'd0, out_data}, {24'd0, 40'h00_0000_0110});
    chk("const_par", {63'd0, out_par}, 64'd0);
    idle(1'b1);

    // Backpressure
    send(20'h00003, 1'b0);
    exp_a = out_data;
    send(20'h00005, 1'b0);
    chk("bp_hold", {24'd0, out_data}, {24'd0, exp_a});
    chk("bp_cnt_hold", {60'd0, xfer_cnt}, 64'd2);
    send(20'h00005, 1'b1);
    chk("bp_valid", {63'd0, out_valid}, 64'd1);
    chk("bp_cnt_a", {60'd0, xfer_cnt}, 64'd3);
    idle(1'b1);
    chk("bp_cnt_b", {60'd0, xfer_cnt}, 64'd4);

    // Illegal configuration
    cycle(1'b0, '0, 1'b1, 1'b1, 6'd0, 5'd22, 1'b1);
    cycle(1'b0, '0, 1'b1, 1'b1, 6'd40, 5'd0, 1'b1);
    chk("ill_err", {63'd0, cfg_err}, 64'd1);
    send(20'hA_5C3E, 1'b1);
    chk("ill_bit0", {63'd0, out_data[0]}, 64'd0);
    chk("ill_bit1", {63'd0, out_data[1]}, 64'd1);
    idle(1'b1);
    chk("ill_err_sticky", {63'd0, cfg_err}, 64'd1);

    // Same-edge map write and capture
    cycle(1'b1, 20'h00001, 1'b1, 1'b1, 6'd0, 5'd1, 1'b0);
    chk("order_old", {63'd0, out_data[0]}, 64'd1);
    send(20'h00001, 1'b1);
    chk("order_new", {63'd0, out_data[0]}, 64'd0);
    idle(1'b1);

    // Randomized traffic with interleaved (sometimes illegal) map writes
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 3) != 0), 20'($urandom()), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 4) == 0), 6'($urandom_range(0, 43)),
            5'($urandom_range(0, 23)), 1'($urandom_range(0, 1)));
    end
    idle(1'b1);
    idle(1'b1);

    // Counter wrap, then reset with a held word
    do_reset();
    for (int i = 0; i < 17; i++) send(20'($urandom()), 1'b1);
    idle(1'b1);
    chk("wrap_cnt", {60'd0, xfer_cnt}, 64'd1);
    send(20'h1_2345, 1'b0);
    chk("held_valid", {63'd0, out_valid}, 64'd1);
    do_reset();
    idle(1'b1);
    chk("post_rst_valid", {63'd0, out_valid}, 64'd0);
    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
